store_pack_buffer: RTL and testbench
====================================

# store_pack_buffer

Store-side data packer and write buffer between the MEM stage and data memory: the inverse of the immediate/load extenders, narrowing 32-bit register data to byte/half/word writes. Each accepted store request is converted into a word-aligned address, lane-replicated write data and a 4-bit byte enable. The result is queued in a small FIFO and drained to memory over a valid/ready handshake, so memory stalls do not immediately back-pressure the pipeline.

## Interface
- `DEPTH`, default 2: FIFO entries; a power of two, at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state while low.
- `req_valid` in 1: a store request is presented.
- `req_ready` out 1: the request is accepted on an edge where `req_valid & req_ready`.
- `req_op` in 3: 3'b000 SW, 3'b001 SH, 3'b010 SB; all other encodings are invalid.
- `req_addr` in 32: byte address.
- `req_data` in 32: source register value.
- `mem_valid` out 1: the FIFO head is presented to memory.
- `mem_ready` in 1: memory takes the head on an edge where `mem_valid & mem_ready`.
- `mem_addr` out 32: `{req_addr[31:2], 2'b00}` of the head entry.
- `mem_wdata` out 32: packed write data of the head entry.
- `mem_be` out 4: byte enables of the head entry; bit i enables bits [8i+7:8i].
- `count` out $clog2(DEPTH)+1: number of occupied entries.
- `idle` out 1: `count == 0`.
- `exc_valid` out 1: one-cycle pulse for a misaligned store. Present only with `STORE_EXC_EN`.
- `exc_addr` out 32: the faulting `req_addr`. Present only with `STORE_EXC_EN`.

## Operation
- Packing:
  - SW: `be=4'b1111`, `wdata=req_data`.
  - SH: `be = req_addr[1] ? 4'b1100 : 4'b0011`, `wdata={2{req_data[15:0]}}`.
  - SB: `be = 4'b0001 << req_addr[1:0]`, `wdata={4{req_data[7:0]}}`.
- Invalid `req_op`: the request is accepted (handshake completes) but dropped. Nothing is enqueued and no exception is raised.
- `req_ready = (count < DEPTH)`, derived from registered state only. It does not depend on `mem_ready`, so there is no full-bypass: a request presented while full waits even if the head pops that same cycle.
- Enqueue on accept; dequeue on the memory handshake. Both may happen on the same edge, leaving `count` unchanged.
- Read and write pointers wrap modulo DEPTH.
- Strict FIFO order; no merging or coalescing of entries.
- `mem_valid = !idle`. `mem_addr`, `mem_wdata` and `mem_be` come from the head entry and hold stable while `mem_valid & !mem_ready`.
- When `mem_valid` is low, `mem_addr`, `mem_wdata` and `mem_be` are 0.

## Timing
- Reset (`reset` low, asynchronous):
  - `count=0`, pointers 0, `idle=1`, `req_ready=1`.
  - `mem_valid=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0`.
  - `exc_valid=0`, `exc_addr=0`.
- Reset asserted mid-operation discards every queued entry; no partial write is issued.
- Latency: a request accepted at edge N gives `mem_valid=1` for that entry in the cycle after edge N.
- Throughput: one store per cycle when `mem_ready` is held high.
- Full (`count==DEPTH`): `req_ready=0`. A pop at edge N makes `req_ready=1` in the following cycle.
- Empty with `mem_ready` high: nothing is popped; `count` never underflows.

## Configuration
- `STORE_EXC_EN` defined:
  - SH with `req_addr[0]=1`, or SW with `req_addr[1:0]!=0`, is accepted but not enqueued.
  - `exc_valid` pulses for the one cycle after the accept edge, with `exc_addr=req_addr`. Otherwise `exc_valid=0`.
  - A later fault overwrites `exc_addr`.
- `STORE_EXC_EN` undefined:
  - The `exc_*` ports are absent.
  - Misaligned low address bits are ignored: SW is written as a full word, and SH selects its half with `req_addr[1]` only.

## Test plan
- SB, `addr=0x0000_1003`, `data=0x1122_3344`, `mem_ready=1` -> the next cycle shows `mem_addr=0x0000_1000`, `mem_be=4'b1000`, `mem_wdata=0x4444_4444`, `mem_valid=1` for 1 cycle.
- SH at `0x0000_2002`, data `0xAAAA_BEEF`, then SW at `0x0000_2004`, data `0xDEAD_BEEF`, with `mem_ready=0` -> `count=2`, `req_ready=0`. Set `mem_ready=1` -> `be=1100/wdata=BEEF_BEEF` is issued, then `be=1111/wdata=DEAD_BEEF`, then `idle=1`.
- Full FIFO with a new `req_valid` and `mem_ready=1` on the same edge -> the new request is not accepted that edge. It is accepted on the next edge and drained third.
- `req_op=3'b111` -> the handshake completes, `count` stays 0, and `mem_valid` stays 0.
- With `STORE_EXC_EN`: SW at `0x0000_3001` -> `exc_valid=1` for 1 cycle with `exc_addr=0x0000_3001`, `count` stays 0. Without the macro, the same request writes `mem_addr=0x0000_3000` with `be=4'b1111`.
- `reset` driven low asynchronously with 2 entries queued and `mem_valid=1` -> `mem_valid=0`, `count=0` and `idle=1` immediately, with no edge needed. After release the FIFO accepts new requests normally.

Source files
------------

// File: rtl/store_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_pack_buffer
// Purpose  : Store-side packer and write buffer between the MEM stage and
//            data memory. Each accepted store (SW/SH/SB) is turned into a
//            word-aligned address, lane-replicated write data and a 4-bit
//            byte enable, queued in a DEPTH-entry FIFO and drained to memory
//            over a valid/ready handshake.
// Ports    : clk, reset (async, active-low)
//            req_valid/req_ready/req_op/req_addr/req_data : store request
//            mem_valid/mem_ready/mem_addr/mem_wdata/mem_be: memory write
//            count, idle                                  : occupancy
//            exc_valid, exc_addr                          : misaligned store
//                                                           (STORE_EXC_EN only)
// Config   : `define STORE_EXC_EN to trap misaligned SH/SW instead of
//            silently ignoring the low address bits.
// Revision : 1.0 - initial release
// ============================================================================
module store_pack_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_data,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
`ifdef STORE_EXC_EN
  ,
  output logic                     exc_valid,
  output logic [31:0]              exc_addr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [2:0] OP_SW = 3'b000;
  localparam logic [2:0] OP_SH = 3'b001;
  localparam logic [2:0] OP_SB = 3'b010;

  // FIFO storage and control state
  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      addr_d  [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [3:0]       be_d    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  // Packed form of the incoming request
  logic        op_ok;
  logic        misaligned;
  logic [3:0]  pack_be;
  logic [31:0] pack_wdata;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    op_ok      = 1'b1;
    pack_be    = 4'b0000;
    pack_wdata = 32'h0;
    case (req_op)
      OP_SW: begin
        pack_be    = 4'b1111;
        pack_wdata = req_data;
      end
      OP_SH: begin
        pack_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        pack_wdata = {2{req_data[15:0]}};
      end
      OP_SB: begin
        pack_be    = 4'b0001 << req_addr[1:0];
        pack_wdata = {4{req_data[7:0]}};
      end
      default: op_ok = 1'b0;
    endcase
  end

`ifdef STORE_EXC_EN
  always_comb begin
    misaligned = ((req_op == OP_SW) && (req_addr[1:0] != 2'b00)) ||
                 ((req_op == OP_SH) && req_addr[0]);
  end
`else
  always_comb begin
    misaligned = 1'b0;
  end
`endif

  // Ready depends only on registered occupancy: no same-cycle full bypass.
  assign req_ready = (count_q < DEPTH_C);
  assign accept    = req_valid & req_ready;
  // Invalid opcodes and trapped stores complete the handshake but are dropped.
  assign push      = accept & op_ok & ~misaligned;
  assign pop       = mem_valid & mem_ready;

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      addr_d[wr_ptr_q]  = {req_addr[31:2], 2'b00};
      wdata_d[wr_ptr_q] = pack_wdata;
      be_d[wr_ptr_q]    = pack_be;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= 32'h0;
        wdata_q[i] <= 32'h0;
        be_q[i]    <= 4'b0000;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count     = count_q;
  assign idle      = (count_q == '0);
  assign mem_valid = ~idle;
  // Outputs are forced to zero while nothing is presented.
  assign mem_addr  = mem_valid ? addr_q[rd_ptr_q]  : 32'h0;
  assign mem_wdata = mem_valid ? wdata_q[rd_ptr_q] : 32'h0;
  assign mem_be    = mem_valid ? be_q[rd_ptr_q]    : 4'b0000;

`ifdef STORE_EXC_EN
  logic        exc_valid_q, exc_valid_d;
  logic [31:0] exc_addr_q,  exc_addr_d;

  always_comb begin
    exc_valid_d = accept & op_ok & misaligned;
    exc_addr_d  = exc_valid_d ? req_addr : exc_addr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_valid_q <= 1'b0;
      exc_addr_q  <= 32'h0;
    end else begin
      exc_valid_q <= exc_valid_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign exc_valid = exc_valid_q;
  assign exc_addr  = exc_addr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_pack_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_pack_buffer
// Purpose  : Directed self-checking bench for store_pack_buffer (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_pack_buffer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  count;
  logic        idle;
`ifdef STORE_EXC_EN
  logic        exc_valid;
  logic [31:0] exc_addr;
`endif

  int checks = 0;
  int errors = 0;

  store_pack_buffer #(.DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .count     (count),
    .idle      (idle)
`ifdef STORE_EXC_EN
    ,
    .exc_valid (exc_valid),
    .exc_addr  (exc_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    mem_ready = 1'b0;

    // Reset state
    #3;
    check_eq("rst_count",     32'(count),     32'd0);
    check_eq("rst_idle",      32'(idle),      32'd1);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_mem_addr",  mem_addr,       32'h0);
    check_eq("rst_mem_wdata", mem_wdata,      32'h0);
    check_eq("rst_mem_be",    32'(mem_be),    32'h0);
`ifdef STORE_EXC_EN
    check_eq("rst_exc_valid", 32'(exc_valid), 32'd0);
    check_eq("rst_exc_addr",  exc_addr,       32'h0);
`endif
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();

    // SB at byte 3 with memory ready: one-cycle presentation
    mem_ready = 1'b1;
    drive_req(3'b010, 32'h0000_1003, 32'h1122_3344);
    tick();
    req_valid = 1'b0;
    check_eq("sb_valid", 32'(mem_valid), 32'd1);
    check_eq("sb_addr",  mem_addr,       32'h0000_1000);
    check_eq("sb_be",    32'(mem_be),    32'h8);
    check_eq("sb_wdata", mem_wdata,      32'h4444_4444);
    tick();
    check_eq("sb_gone_valid", 32'(mem_valid), 32'd0);
    check_eq("sb_gone_be",    32'(mem_be),    32'h0);
    check_eq("sb_gone_idle",  32'(idle),      32'd1);

    // SH + SW with memory stalled, then drain in order
    mem_ready = 1'b0;
    drive_req(3'b001, 32'h0000_2002, 32'hAAAA_BEEF);
    tick();
    drive_req(3'b000, 32'h0000_2004, 32'hDEAD_BEEF);
    tick();
    req_valid = 1'b0;
    check_eq("full_count",     32'(count),     32'd2);
    check_eq("full_req_ready", 32'(req_ready), 32'd0);
    check_eq("sh_be",          32'(mem_be),    32'hC);
    check_eq("sh_wdata",       mem_wdata,      32'hBEEF_BEEF);
    check_eq("sh_addr",        mem_addr,       32'h0000_2000);
    tick();
    check_eq("stall_hold_be",    32'(mem_be), 32'hC);
    check_eq("stall_hold_wdata", mem_wdata,   32'hBEEF_BEEF);
    mem_ready = 1'b1;
    tick();
    check_eq("sw_be",        32'(mem_be),    32'hF);
    check_eq("sw_wdata",     mem_wdata,      32'hDEAD_BEEF);
    check_eq("sw_addr",      mem_addr,       32'h0000_2004);
    check_eq("pop_reopens",  32'(req_ready), 32'd1);
    tick();
    check_eq("drain_idle",   32'(idle),      32'd1);

    // Full FIFO with a new request and a pop on the same edge
    mem_ready = 1'b0;
    drive_req(3'b010, 32'h0000_0010, 32'h0000_0001);
    tick();
    drive_req(3'b010, 32'h0000_0011, 32'h0000_0002);
    tick();
    drive_req(3'b010, 32'h0000_0012, 32'h0000_0003);
    mem_ready = 1'b1;
    tick();
    check_eq("nobypass_count", 32'(count),  32'd1);
    check_eq("nobypass_head",  32'(mem_be), 32'h2);
    check_eq("nobypass_wdata", mem_wdata,   32'h0202_0202);
    tick();
    req_valid = 1'b0;
    check_eq("third_count", 32'(count),  32'd1);
    check_eq("third_be",    32'(mem_be), 32'h4);
    check_eq("third_wdata", mem_wdata,   32'h0303_0303);
    tick();
    check_eq("third_drained", 32'(idle), 32'd1);

    // Invalid opcode: accepted, dropped
    drive_req(3'b111, 32'h0000_5000, 32'h1234_5678);
    #1;
    check_eq("inv_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check_eq("inv_count", 32'(count),     32'd0);
    check_eq("inv_valid", 32'(mem_valid), 32'd0);

    // Misaligned SW
    mem_ready = 1'b0;
    drive_req(3'b000, 32'h0000_3001, 32'h1234_5678);
    tick();
    req_valid = 1'b0;
`ifdef STORE_EXC_EN
    check_eq("exc_valid", 32'(exc_valid), 32'd1);
    check_eq("exc_addr",  exc_addr,       32'h0000_3001);
    check_eq("exc_count", 32'(count),     32'd0);
    tick();
    check_eq("exc_pulse_end", 32'(exc_valid), 32'd0);
`else
    check_eq("mis_sw_addr",  mem_addr,    32'h0000_3000);
    check_eq("mis_sw_be",    32'(mem_be), 32'hF);
    check_eq("mis_sw_wdata", mem_wdata,   32'h1234_5678);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    drive_req(3'b001, 32'h0000_3003, 32'h0000_CAFE);
    tick();
    req_valid = 1'b0;
    check_eq("mis_sh_be",    32'(mem_be), 32'hC);
    check_eq("mis_sh_wdata", mem_wdata,   32'hCAFE_CAFE);
    mem_ready = 1'b1;
    tick();
    check_eq("mis_drained", 32'(idle), 32'd1);
`endif

    // Asynchronous reset with two entries queued
    mem_ready = 1'b0;
    drive_req(3'b000, 32'h0000_6000, 32'h1111_1111);
    tick();
    drive_req(3'b000, 32'h0000_6004, 32'h2222_2222);
    tick();
    req_valid = 1'b0;
    check_eq("pre_rst_count", 32'(count),     32'd2);
    check_eq("pre_rst_valid", 32'(mem_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", 32'(mem_valid), 32'd0);
    check_eq("arst_count", 32'(count),     32'd0);
    check_eq("arst_idle",  32'(idle),      32'd1);
    check_eq("arst_ready", 32'(req_ready), 32'd1);
    check_eq("arst_be",    32'(mem_be),    32'h0);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    drive_req(3'b000, 32'h0000_4000, 32'hCAFE_F00D);
    tick();
    req_valid = 1'b0;
    check_eq("post_rst_addr",  mem_addr,    32'h0000_4000);
    check_eq("post_rst_wdata", mem_wdata,   32'hCAFE_F00D);
    check_eq("post_rst_be",    32'(mem_be), 32'hF);
    check_eq("post_rst_count", 32'(count),  32'd1);
    tick();
    check_eq("post_rst_idle", 32'(idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
